// File: rtl/riscv_pkg.sv
// Shared opcode constants and hazard-controller state encoding for the 5-stage core.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int SQ_W = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1
    } hz_state_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_SD) || (op == OP_BEQ) ||
               (op == OP_I) || (op == OP_LD);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_SD) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter for debug statistics; holds at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + ONE;
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch squash window and
// data-memory freezes, with saturating stall/flush debug counters.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       if_id_ctrl,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Squash counter holds the number of FLUSH cycles still to come after this one.
    localparam logic [SQ_W-1:0] SQ_RELOAD = (FLUSH_CYCLES > 0) ? SQ_W'(FLUSH_CYCLES - 1) : '0;
    localparam logic [SQ_W-1:0] SQ_ONE    = {{(SQ_W-1){1'b0}}, 1'b1};
    localparam logic            SQ_ENTER  = (FLUSH_CYCLES > 0);

    hz_state_t       r_state;
    hz_state_t       w_state_nxt;
    logic [SQ_W-1:0] r_sq;
    logic [SQ_W-1:0] w_sq_nxt;
    logic            w_load_use;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_stall_inc;
    logic            w_flush_inc;

    assign w_rs1_hit  = uses_rs1(if_id_ctrl) && (id_ex_rd == if_id_rs1);
    assign w_rs2_hit  = uses_rs2(if_id_ctrl) && (id_ex_rd == if_id_rs2);
    assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_sq    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sq    <= w_sq_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sq_nxt    = r_sq;
        if (!mem_busy) begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken && SQ_ENTER) begin
                        w_state_nxt = ST_FLUSH;
                        w_sq_nxt    = SQ_RELOAD;
                    end
                end
                ST_FLUSH: begin
                    if (branch_taken) begin
                        w_sq_nxt = SQ_RELOAD;
                    end else if (r_sq == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_sq_nxt = r_sq - SQ_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_sq_nxt    = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        if (rst) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end else if (mem_busy) begin
            // EX is frozen, so any branch or load-use is re-presented next cycle.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            w_stall_inc = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        w_flush_inc  = 1'b1;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        w_stall_inc  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_flush_inc  = branch_taken;
                end
                default: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign state_o = r_state;

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush_inc),
        .o_count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized cycles against a
// squash-window / saturating-count reference model.
module tb_hazard_ctrl;

    localparam int FC  = 2;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk;
    logic          rst;
    logic [6:0]    if_id_ctrl;
    logic [4:0]    if_id_rs1;
    logic [4:0]    if_id_rs2;
    logic          id_ex_mem_read;
    logic [4:0]    id_ex_rd;
    logic          branch_taken;
    logic          mem_busy;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          pipe_hold;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int checks   = 0;
    int failures = 0;
    int m_rem    = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_ctrl     (if_id_ctrl),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .pipe_hold      (pipe_hold),
        .state_o        (state_o),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_lu();
        bit u1 = 0;
        bit u2 = 0;
        case (if_id_ctrl)
            7'b0110011, 7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
            7'b0010011, 7'b0000011:             u1 = 1;
            default:                            ;
        endcase
        return id_ex_mem_read && (id_ex_rd != 0) &&
               ((u1 && id_ex_rd == if_id_rs1) || (u2 && id_ex_rd == if_id_rs2));
    endfunction

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, state[1:0]}
    function automatic logic [6:0] model_out();
        logic [1:0] st = (m_rem > 0) ? 2'd1 : 2'd0;
        if (rst)               return 7'b1100000;
        if (mem_busy)          return {5'b00001, st};
        if (m_rem > 0)         return 7'b1111001;
        if (branch_taken)      return 7'b1111000;
        if (model_lu())        return 7'b0001000;
        return 7'b1100000;
    endfunction

    function automatic logic [6:0] dut_out();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, state_o};
    endfunction

    task automatic model_clear();
        m_rem = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else if (mem_busy) begin
            if (m_stall < SAT) m_stall++;
        end else if (branch_taken) begin
            if (m_flush < SAT) m_flush++;
            m_rem = FC;
        end else if (m_rem > 0) m_rem--;
        else if (model_lu()) begin
            if (m_stall < SAT) m_stall++;
        end
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input int r1, input int r2,
                         input logic mr, input int rd, input logic br, input logic mb);
        if_id_ctrl = op; if_id_rs1 = 5'(r1); if_id_rs2 = 5'(r2);
        id_ex_mem_read = mr; id_ex_rd = 5'(rd); branch_taken = br; mem_busy = mb;
    endtask

    task automatic test_reset();
        drive(7'b0110011, 5, 5, 1, 5, 1, 1);
        rst = 1'b1;
        #2;
        checks++;
        if (dut_out() !== 7'b1100000) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", dut_out(), 7'b1100000);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || dut_out() !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_hold got=%b/%0d/%0d exp=1100000/0/0", dut_out(), stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        model_clear();
        drive(7'b0110011, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        drive(7'b0110011, 5, 7, 1, 5, 0, 0);
        @(negedge clk);
        checks++;
        if (dut_out() !== 7'b0001000) begin
            failures++; $display("FAIL load_use_stall got=%b exp=%b", dut_out(), 7'b0001000);
        end
        tick();
        id_ex_mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_out() !== 7'b1100000 || stall_cnt !== 4'd1) begin
            failures++; $display("FAIL load_use_after got=%b/%0d exp=1100000/1", dut_out(), stall_cnt);
        end
        tick();
    endtask

    task automatic test_no_false_hazard();
        drive(7'b0110011, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (dut_out() !== 7'b1100000) begin
            failures++; $display("FAIL ld_x0 got=%b exp=%b", dut_out(), 7'b1100000);
        end
        tick();
        drive(7'b0010011, 3, 5, 1, 5, 0, 0);
        @(negedge clk);
        checks++;
        if (dut_out() !== 7'b1100000) begin
            failures++; $display("FAIL addi_alias got=%b exp=%b", dut_out(), 7'b1100000);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'(m_stall)) begin
            failures++; $display("FAIL no_false_cnt got=%0d exp=%0d", stall_cnt, m_stall);
        end
        drive(7'b0110011, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        logic [6:0] e [4] = '{7'b1111000, 7'b1111001, 7'b1111001, 7'b1100000};
        int f0 = m_flush;
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== e[i]) begin
                failures++; $display("FAIL branch_seq[%0d] got=%b exp=%b", i, dut_out(), e[i]);
            end
            tick();
            branch_taken = 1'b0;
        end
        checks++;
        if (flush_cnt !== 4'(f0 + 1)) begin
            failures++; $display("FAIL branch_cnt got=%0d exp=%0d", flush_cnt, f0 + 1);
        end
    endtask

    task automatic test_mem_busy_flush();
        logic [6:0] e [7] = '{7'b1111000, 7'b0000101, 7'b0000101, 7'b0000101,
                              7'b0000101, 7'b1111001, 7'b1111001};
        int s0 = m_stall;
        branch_taken = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== e[i]) begin
                failures++; $display("FAIL busy_flush[%0d] got=%b exp=%b", i, dut_out(), e[i]);
            end
            tick();
            branch_taken = 1'b0;
            mem_busy = (i < 4);
        end
        @(negedge clk);
        checks++;
        if (dut_out() !== 7'b1100000 || stall_cnt !== 4'(s0 + 4)) begin
            failures++;
            $display("FAIL busy_resume got=%b/%0d exp=1100000/%0d", dut_out(), stall_cnt, s0 + 4);
        end
        tick();
    endtask

    task automatic test_branch_vs_load_use();
        int s0 = m_stall;
        int f0 = m_flush;
        drive(7'b0110011, 5, 7, 1, 5, 1, 0);
        @(negedge clk);
        checks++;
        if (dut_out() !== 7'b1111000) begin
            failures++; $display("FAIL br_vs_lu got=%b exp=%b", dut_out(), 7'b1111000);
        end
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== 7'b1111001) begin
                failures++; $display("FAIL flush_ignores_lu[%0d] got=%b exp=%b", i, dut_out(), 7'b1111001);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 4'(s0) || flush_cnt !== 4'(f0 + 1)) begin
            failures++;
            $display("FAIL br_vs_lu_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, s0, f0 + 1);
        end
        id_ex_mem_read = 1'b0;
    endtask

    task automatic test_saturation();
        drive(7'b0100011, 2, 9, 1, 9, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out() !== 7'b0001000 || stall_cnt !== 4'(m_stall)) begin
                failures++;
                $display("FAIL sat_stall[%0d] got=%b/%0d exp=0001000/%0d", i, dut_out(), stall_cnt, m_stall);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++; $display("FAIL sat_final got=%0d exp=15", stall_cnt);
        end
        id_ex_mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (state_o !== 2'd1) begin
            failures++; $display("FAIL pre_rst_state got=%0d exp=1", state_o);
        end
        #2 rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || dut_out() !== 7'b1100000) begin
            failures++;
            $display("FAIL async_rst got=%b/%0d/%0d exp=1100000/0/0", dut_out(), stall_cnt, flush_cnt);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0000000};
        logic [6:0] op;
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            drive(op, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
            rst = ($urandom_range(0, 59) == 0);
            if (rst) model_clear();
            @(negedge clk);
            checks++;
            if (dut_out() !== model_out() || stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
                failures++;
                $display("FAIL random[%0d] got=%b/%0d/%0d exp=%b/%0d/%0d", i, dut_out(), stall_cnt,
                         flush_cnt, model_out(), m_stall, m_flush);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch();
        test_mem_busy_flush();
        test_branch_vs_load_use();
        test_saturation();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
